cpu_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the 16-bit CPU datapath. Fetches one instruction word
//  (opcode[15:12], A[11:6], B[5:0]), classifies it (ALU/IMM/MOV/MEM/NOP), drives register-file,
//  ALU and data-memory enables, and advances the program counter.

---
 rtl/cpu_ctrl_pkg.sv | 63 ++++++
 rtl/cpu_ctrl_fsm_if.sv | 40 ++++
 rtl/cpu_mem_wait_timer.sv | 27 ++
 rtl/cpu_ctrl_fsm.sv | 177 +++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, FSM states,
// instruction classes and IR field positions.
package cpu_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 6;

  localparam int unsigned IR_OP_HI = 15;
  localparam int unsigned IR_OP_LO = 12;
  localparam int unsigned IR_A_HI  = 11;
  localparam int unsigned IR_A_LO  = 6;
  localparam int unsigned IR_B_HI  = 5;
  localparam int unsigned IR_B_LO  = 0;

  localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OP_W-1:0] OP_ALU_LO = 4'h1;
  localparam logic [OP_W-1:0] OP_ALU_HI = 4'h7;
  localparam logic [OP_W-1:0] OP_ADDI   = 4'h8;
  localparam logic [OP_W-1:0] OP_SUBI   = 4'h9;
  localparam logic [OP_W-1:0] OP_MOV    = 4'hA;
  localparam logic [OP_W-1:0] OP_MOVI   = 4'hB;
  localparam logic [OP_W-1:0] OP_LOAD   = 4'hC;
  localparam logic [OP_W-1:0] OP_STORE  = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_IMM,
    CLS_MOV,
    CLS_MEM,
    CLS_ILL
  } op_class_t;

  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    op_class_t cls;
    case (op) inside
      OP_NOP:                 cls = CLS_NOP;
      [OP_ALU_LO:OP_ALU_HI]:  cls = CLS_ALU;
      OP_ADDI, OP_SUBI:       cls = CLS_IMM;
      OP_MOV, OP_MOVI:        cls = CLS_MOV;
      OP_LOAD, OP_STORE:      cls = CLS_MEM;
      default:                cls = CLS_ILL;
    endcase
    return cls;
  endfunction

  // Operand B comes from the zero-extended IR[5:0] field for these opcodes.
  function automatic logic uses_imm(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_MOVI);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Bus bundle between the control sequencer and instruction memory,
// register file / ALU and data memory.
interface cpu_ctrl_fsm_if #(
  parameter int unsigned PC_W = 8
) ();
  import cpu_ctrl_pkg::*;

  logic               start;
  logic [INSTR_W-1:0] instr_in;
  logic               instr_valid;
  logic               mem_ack;

  logic               fetch_req;
  logic [PC_W-1:0]    pc;
  logic [REG_W-1:0]   rf_raddr_a;
  logic [REG_W-1:0]   rf_raddr_b;
  logic [REG_W-1:0]   rf_waddr;
  logic               rf_we;
  logic               alu_en;
  logic [OP_W-1:0]    alu_op;
  logic               imm_sel;
  logic               mem_req;
  logic               mem_we;
  logic               busy;
  logic               halted;
  logic               err;

  modport master (
    input  start, instr_in, instr_valid, mem_ack,
    output fetch_req, pc, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we,
           alu_en, alu_op, imm_sel, mem_req, mem_we, busy, halted, err
  );

  modport slave (
    output start, instr_in, instr_valid, mem_ack,
    input  fetch_req, pc, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we,
           alu_en, alu_op, imm_sel, mem_req, mem_we, busy, halted, err
  );

endinterface

// File: rtl/cpu_mem_wait_timer.sv
// Counts cycles spent waiting on data memory; o_expired flags that the
// count has reached MEM_WAIT_MAX.
module cpu_mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == CNT_W'(MEM_WAIT_MAX));

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU datapath.
// Optional: define ILLEGAL_OP_TRAP_EN to halt with err on opcodes 1110/1111.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W         = 8,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int unsigned     MEM_WAIT_MAX = 15
) (
  input logic            clk,
  input logic            rst,
  cpu_ctrl_fsm_if.master bus
);

  state_t             r_state;
  state_t             w_next_state;
  logic [INSTR_W-1:0] r_ir;
  logic [PC_W-1:0]    r_pc;
  logic               r_err;

  logic [OP_W-1:0]    w_op;
  op_class_t          w_cls;
  logic               w_pc_inc;
  logic               w_set_err;
  logic               w_timer_en;
  logic               w_mem_expired;

  logic               w_fetch_req;
  logic               w_alu_en;
  logic               w_imm_sel;
  logic               w_rf_we;
  logic               w_mem_req;
  logic               w_mem_we;
  logic               w_busy;
  logic               w_halted;

  assign w_op  = r_ir[IR_OP_HI:IR_OP_LO];
  assign w_cls = classify(w_op);

  // Counting on entry (not on the first MEM cycle) makes the count equal the
  // number of MEM cycles so far, so expiry lands on the MEM_WAIT_MAX-th cycle.
  assign w_timer_en = (w_next_state == ST_MEM);

  cpu_mem_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_timer_en),
    .i_en      (w_timer_en),
    .o_expired (w_mem_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir  <= '0;
      r_pc  <= RESET_PC;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_FETCH && bus.instr_valid) begin
        r_ir <= bus.instr_in;
      end
      if (w_pc_inc) begin
        r_pc <= r_pc + 1'b1;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_inc     = 1'b0;
    w_set_err    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.instr_valid) w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        unique case (w_cls)
          CLS_NOP: begin
            w_pc_inc     = 1'b1;
            w_next_state = ST_FETCH;
          end
          CLS_ALU, CLS_IMM, CLS_MOV: w_next_state = ST_EXEC;
          CLS_MEM: w_next_state = ST_MEM;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            w_set_err    = 1'b1;
            w_next_state = ST_HALT;
`else
            w_pc_inc     = 1'b1;
            w_next_state = ST_FETCH;
`endif
          end
        endcase
      end
      ST_EXEC: w_next_state = ST_WB;
      ST_MEM: begin
        if (bus.mem_ack) begin
          if (w_op == OP_STORE) begin
            w_pc_inc     = 1'b1;
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_WB;
          end
        end else if (w_mem_expired) begin
          w_set_err    = 1'b1;
          w_next_state = ST_HALT;
        end
      end
      ST_WB: begin
        w_pc_inc     = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Reset masks every strobe combinationally so requests drop in the rst cycle.
  always_comb begin
    w_fetch_req = 1'b0;
    w_alu_en    = 1'b0;
    w_imm_sel   = 1'b0;
    w_rf_we     = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_busy      = 1'b0;
    w_halted    = 1'b0;
    if (!rst) begin
      w_busy = (r_state != ST_IDLE) && (r_state != ST_HALT);
      case (r_state)
        ST_FETCH: w_fetch_req = 1'b1;
        ST_EXEC: begin
          w_alu_en  = 1'b1;
          w_imm_sel = uses_imm(w_op);
        end
        ST_MEM: begin
          w_mem_req = 1'b1;
          w_mem_we  = (w_op == OP_STORE);
        end
        ST_WB:   w_rf_we  = 1'b1;
        ST_HALT: w_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.fetch_req  = w_fetch_req;
  assign bus.pc         = r_pc;
  assign bus.rf_raddr_a = rst ? '0 : r_ir[IR_A_HI:IR_A_LO];
  assign bus.rf_raddr_b = rst ? '0 : r_ir[IR_B_HI:IR_B_LO];
  assign bus.rf_waddr   = rst ? '0 : r_ir[IR_A_HI:IR_A_LO];
  assign bus.rf_we      = w_rf_we;
  assign bus.alu_en     = w_alu_en;
  assign bus.alu_op     = rst ? '0 : w_op;
  assign bus.imm_sel    = w_imm_sel;
  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_we;
  assign bus.busy       = w_busy;
  assign bus.halted     = w_halted;
  assign bus.err        = r_err && !rst;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized self-checking bench for cpu_ctrl_fsm against a per-instruction
// cycle-script model; honours ILLEGAL_OP_TRAP_EN when defined.
module tb_cpu_ctrl_fsm;

  localparam int unsigned PC_W         = 4;
  localparam int unsigned PC_MOD       = 1 << PC_W;
  localparam int unsigned MEM_WAIT_MAX = 15;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int unsigned OUT_DONE   = 0;
  localparam int unsigned OUT_HALTED = 1;
  localparam int unsigned OUT_RESET  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_ctrl_fsm_if #(.PC_W(PC_W)) bus ();

  cpu_ctrl_fsm #(
    .PC_W         (PC_W),
    .RESET_PC     (4'd0),
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp   = 0;
  int unsigned n_bad   = 0;
  int unsigned exp_pc  = 0;
  bit          exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.start       = 1'($urandom);
    bus.instr_valid = 1'($urandom);
    bus.instr_in    = 16'($urandom);
    bus.mem_ack     = 1'($urandom);
  endtask

  task automatic expect_cycle(input string ph, input bit fr, input bit ae, input bit im,
                              input bit rw, input bit mr, input bit mw, input bit bz, input bit hl);
    check_eq({ph, ".fetch_req"}, 32'(bus.fetch_req), 32'(fr));
    check_eq({ph, ".alu_en"},    32'(bus.alu_en),    32'(ae));
    check_eq({ph, ".imm_sel"},   32'(bus.imm_sel),   32'(im));
    check_eq({ph, ".rf_we"},     32'(bus.rf_we),     32'(rw));
    check_eq({ph, ".mem_req"},   32'(bus.mem_req),   32'(mr));
    check_eq({ph, ".mem_we"},    32'(bus.mem_we),    32'(mw));
    check_eq({ph, ".busy"},      32'(bus.busy),      32'(bz));
    check_eq({ph, ".halted"},    32'(bus.halted),    32'(hl));
    check_eq({ph, ".err"},       32'(bus.err),       32'(exp_err));
    check_eq({ph, ".pc"},        32'(bus.pc),        exp_pc);
  endtask

  task automatic do_reset();
    noise();
    rst = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    expect_cycle("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst.rf_waddr", 32'(bus.rf_waddr), 0);
    tick();
    exp_pc = 0;
  endtask

  task automatic restart();
    rst = 1'b0;
    noise();
    bus.start = 1'b0;
    @(negedge clk);
    expect_cycle("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    noise();
    bus.start = 1'b1;
    @(negedge clk);
    expect_cycle("idle_start", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wb_cycle(input logic [15:0] ins);
    logic [5:0] a;
    a = ins[11:6];
    noise();
    @(negedge clk);
    expect_cycle("wb", 0, 0, 0, 1, 0, 0, 1, 0);
    check_eq("wb.rf_waddr", 32'(bus.rf_waddr), 32'(a));
    tick();
    exp_pc = (exp_pc + 1) % PC_MOD;
  endtask

  task automatic halt_check();
    for (int unsigned i = 0; i < 3; i++) begin
      noise();
      @(negedge clk);
      expect_cycle("halt", 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
  endtask

  // Expected behaviour is scripted per instruction class straight from the opcode value.
  task automatic run_instr(input logic [15:0] ins, input int unsigned fdly, input int unsigned adly,
                           input int unsigned abort_at, output int unsigned outcome);
    int unsigned op;
    logic [5:0] a, b;
    op = 32'(ins[15:12]);
    a  = ins[11:6];
    b  = ins[5:0];
    outcome = OUT_DONE;
    for (int unsigned i = 0; i <= fdly; i++) begin
      noise();
      bus.instr_valid = (i == fdly);
      if (i == fdly) bus.instr_in = ins;
      @(negedge clk);
      expect_cycle("fetch", 1, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    noise();
    @(negedge clk);
    expect_cycle("decode", 0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("decode.rf_raddr_a", 32'(bus.rf_raddr_a), 32'(a));
    check_eq("decode.rf_raddr_b", 32'(bus.rf_raddr_b), 32'(b));
    check_eq("decode.alu_op",     32'(bus.alu_op),     op);
    tick();
    if (op == 0 || (op >= 14 && !TRAP)) begin
      exp_pc = (exp_pc + 1) % PC_MOD;
      return;
    end
    if (op >= 14) begin
      exp_err = 1'b1;
      outcome = OUT_HALTED;
      return;
    end
    if (op <= 11) begin
      noise();
      @(negedge clk);
      expect_cycle("exec", 0, 1, (op == 8 || op == 9 || op == 11), 0, 0, 0, 1, 0);
      check_eq("exec.alu_op", 32'(bus.alu_op), op);
      tick();
      wb_cycle(ins);
      return;
    end
    for (int unsigned c = 1; c <= MEM_WAIT_MAX; c++) begin
      noise();
      if (c == abort_at) begin
        rst = 1'b1;
        exp_err = 1'b0;
        @(negedge clk);
        expect_cycle("mem_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        exp_pc = 0;
        outcome = OUT_RESET;
        return;
      end
      bus.mem_ack = (c == adly);
      @(negedge clk);
      expect_cycle("mem", 0, 0, 0, 0, 1, (op == 13), 1, 0);
      tick();
      if (c == adly) begin
        if (op == 12) wb_cycle(ins);
        else exp_pc = (exp_pc + 1) % PC_MOD;
        return;
      end
    end
    exp_err = 1'b1;
    outcome = OUT_HALTED;
  endtask

  task automatic step(input logic [15:0] ins, input int unsigned fdly, input int unsigned adly,
                      input int unsigned abort_at);
    int unsigned outcome;
    run_instr(ins, fdly, adly, abort_at, outcome);
    if (outcome == OUT_HALTED) begin
      halt_check();
      do_reset();
      restart();
    end else if (outcome == OUT_RESET) begin
      restart();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_in    = '0;
    bus.mem_ack     = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    exp_pc = 0;
    do_reset();
    restart();

    // Reset while a fetch is pending, then Add A=1 B=2 delivered one cycle late.
    step(16'h2abc, 0, 1, 0);
    do_reset();
    restart();
    step(16'h1042, 1, 1, 0);
    step(16'hB0C5, 0, 1, 0);
    step(16'hC081, 0, 3, 0);
    step(16'hD081, 2, 3, 0);
    step(16'hC081, 0, 0, 0);
    step(16'hE000, 0, 1, 0);
    step(16'hF3FF, 1, 1, 0);

    while (exp_pc != PC_MOD - 1) step(16'h0000, 0, 1, 0);
    step(16'h0000, 0, 1, 0);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check_eq("pc_wrap", 32'(bus.pc), 0);
    tick();

    step(16'hC081, 0, 0, 2);
    step(16'hD042, 0, 15, 0);

    for (int unsigned n = 0; n < 300; n++) begin
      logic [15:0] ins;
      int unsigned fdly, adly, abort_at;
      ins  = 16'($urandom);
      fdly = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0)      adly = 0;
      else if ($urandom_range(0, 3) == 0) adly = MEM_WAIT_MAX;
      else                                adly = $urandom_range(1, 4);
      abort_at = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 2) : 0;
      step(ins, fdly, adly, abort_at);
      if ($urandom_range(0, 31) == 0) begin
        do_reset();
        restart();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
